// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - handshake/result bundle between the decoder/EX stage and md_unit
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_control;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;

  modport master (
    output start, md_control, rs_val, rt_val, cancel,
    input  busy, done, hi, lo, mf_data
  );

  modport slave (
    input  start, md_control, rs_val, rt_val, cancel,
    output busy, done, hi, lo, mf_data
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle MIPS multiply/divide unit owning HI/LO
// Optional MD_EARLY_OUT_EN: trivial divides (divisor 0 or larger than dividend) skip the shift loop.
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 6
) (
  input logic    clk,
  input logic    rst_n,
  md_unit_if.slave md
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               op_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;

  // Operand magnitudes are taken from the live bus so they can be latched on the accepting edge.
  always_comb begin
    op_signed = ~md.md_control[0];
    mag_a     = (op_signed && md.rs_val[WIDTH-1]) ? -md.rs_val : md.rs_val;
    mag_b     = (op_signed && md.rt_val[WIDTH-1]) ? -md.rt_val : md.rt_val;
  end

  always_comb begin
    ext_a   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = ext_a * ext_b;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          unique case (md.md_control)
            3'b010: hi_d = md.rs_val;
            3'b011: lo_d = md.rs_val;
            3'b100, 3'b101: begin
              a_d     = md.rs_val;
              b_d     = md.rt_val;
              sgn_d   = op_signed;
              cnt_d   = MUL_INIT;
              state_d = MUL;
            end
            3'b110, 3'b111: begin
              a_d    = md.rs_val;
              b_d    = md.rt_val;
              sgn_d  = op_signed;
              dvs_d  = mag_b;
              qneg_d = op_signed & (md.rs_val[WIDTH-1] ^ md.rt_val[WIDTH-1]);
              rneg_d = op_signed & md.rs_val[WIDTH-1];
              div0_d = (md.rt_val == '0);
              cnt_d  = DIV_INIT;
`ifdef MD_EARLY_OUT_EN
              if ((md.rt_val == '0) || (mag_b > mag_a)) begin
                quo_d   = (md.rt_val == '0) ? '1 : '0;
                rem_d   = mag_a;
                state_d = FIX;
              end else begin
                quo_d   = mag_a;
                rem_d   = '0;
                state_d = DIV;
              end
`else
              quo_d   = mag_a;
              rem_d   = '0;
              state_d = DIV;
`endif
            end
            default: ;
          endcase
        end
      end

      MUL: begin
        if (md.cancel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DIV: begin
        if (md.cancel) begin
          state_d = IDLE;
        end else begin
          // Restoring step: keep the subtraction only when it did not borrow.
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      FIX: begin
        if (md.cancel) begin
          state_d = IDLE;
        end else begin
          if (div0_q) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = qneg_q ? -quo_q : quo_q;
            hi_d = rneg_q ? -rem_q : rem_q;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign md.busy = (state_q != IDLE);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  always_comb begin
    unique case (md.md_control)
      3'b000:  md.mf_data = hi_q;
      3'b001:  md.mf_data = lo_q;
      default: md.mf_data = '0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   dn;

`ifdef MD_EARLY_OUT_EN
  localparam int DIV_TRIVIAL_CYC = 1;
`else
  localparam int DIV_TRIVIAL_CYC = 33;
`endif

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32), .MULT_LAT(4), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.md_control = op;
    bus.rs_val     = rs;
    bus.rt_val     = rt;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.md_control = 3'b010;
  endtask

  // Counts busy samples from now on, then done pulses at and one cycle after the drop.
  task automatic wait_done(output int cycles, output int dones);
    cycles = 0;
    dones  = 0;
    while (bus.busy && cycles < 200) begin
      if (bus.done) dones++;
      cycles++;
      @(negedge clk);
    end
    if (bus.done) dones++;
    @(negedge clk);
    if (bus.done) dones++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
  endtask

  task automatic test_mult;
    issue(3'b100, 32'hFFFF_FFFE, 32'h3);
    wait_done(cyc, dn);
    checks++; if (cyc != 4) begin errors++; $display("FAIL mult_busy got %0d exp 4", cyc); end
    checks++; if (dn != 1) begin errors++; $display("FAIL mult_done got %0d exp 1", dn); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", bus.lo); end
    issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, dn);
    checks++; if (cyc != 4) begin errors++; $display("FAIL multu_busy got %0d exp 4", cyc); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
  endtask

  task automatic test_div;
    issue(3'b110, 32'hFFFF_FFF9, 32'h2);
    wait_done(cyc, dn);
    checks++; if (cyc != 33) begin errors++; $display("FAIL div_busy got %0d exp 33", cyc); end
    checks++; if (dn != 1) begin errors++; $display("FAIL div_done got %0d exp 1", dn); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", bus.hi); end
    issue(3'b111, 32'h7, 32'h0);
    wait_done(cyc, dn);
    checks++; if (cyc != DIV_TRIVIAL_CYC) begin errors++; $display("FAIL divu0_busy got %0d exp %0d", cyc, DIV_TRIVIAL_CYC); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got %h exp ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h7) begin errors++; $display("FAIL divu0_hi got %h exp 00000007", bus.hi); end
    issue(3'b110, 32'h0000_0064, 32'hFFFF_FFF9);
    wait_done(cyc, dn);
    checks++; if (bus.lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_neg_lo got %h exp fffffff2", bus.lo); end
    checks++; if (bus.hi !== 32'h2) begin errors++; $display("FAIL div_neg_hi got %h exp 00000002", bus.hi); end
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, dn);
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 0", bus.hi); end
    issue(3'b110, 32'hFFFF_FF9C, 32'h0);
    wait_done(cyc, dn);
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0s_lo got %h exp ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FF9C) begin errors++; $display("FAIL div0s_hi got %h exp ffffff9c", bus.hi); end
  endtask

  task automatic test_mtmf;
    issue(3'b010, 32'h1234, 32'h0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %h exp 1234", bus.hi); end
    issue(3'b011, 32'h5678, 32'h0);
    checks++; if (bus.lo !== 32'h5678) begin errors++; $display("FAIL mtlo_lo got %h exp 5678", bus.lo); end
    bus.start = 1'b1; bus.md_control = 3'b000;
    #1;
    checks++; if (bus.mf_data !== 32'h1234) begin errors++; $display("FAIL mfhi got %h exp 1234", bus.mf_data); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mfhi_busy got %b exp 0", bus.busy); end
    bus.md_control = 3'b001;
    #1;
    checks++; if (bus.mf_data !== 32'h5678) begin errors++; $display("FAIL mflo got %h exp 5678", bus.mf_data); end
    bus.start = 1'b0; bus.md_control = 3'b100;
    #1;
    checks++; if (bus.mf_data !== 32'h0) begin errors++; $display("FAIL mf_other got %h exp 0", bus.mf_data); end
    bus.md_control = 3'b010;
  endtask

  task automatic test_cancel;
    issue(3'b110, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cancel_pre_busy got %b exp 1", bus.busy); end
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b exp 0", bus.busy); end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL cancel_done got %0d exp 0", dn); end
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL cancel_hi got %h exp 1234", bus.hi); end
    checks++; if (bus.lo !== 32'h5678) begin errors++; $display("FAIL cancel_lo got %h exp 5678", bus.lo); end
  endtask

  task automatic test_cancel_commit;
    issue(3'b100, 32'd5, 32'd6);
    repeat (3) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cc_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL cc_done got %b exp 0", bus.done); end
    checks++; if (bus.lo !== 32'h5678) begin errors++; $display("FAIL cc_lo got %h exp 5678", bus.lo); end
  endtask

  task automatic test_start_while_busy;
    issue(3'b100, 32'd2, 32'd3);
    @(negedge clk);
    bus.start = 1'b1; bus.md_control = 3'b011; bus.rs_val = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0; bus.md_control = 3'b010;
    wait_done(cyc, dn);
    checks++; if (cyc != 2) begin errors++; $display("FAIL swb_busy got %0d exp 2", cyc); end
    checks++; if (bus.lo !== 32'h6) begin errors++; $display("FAIL swb_lo got %h exp 6", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL swb_hi got %h exp 0", bus.hi); end
  endtask

  task automatic test_early_out;
    issue(3'b111, 32'd3, 32'd10);
    wait_done(cyc, dn);
    checks++; if (cyc != DIV_TRIVIAL_CYC) begin errors++; $display("FAIL eo_busy got %0d exp %0d", cyc, DIV_TRIVIAL_CYC); end
    checks++; if (dn != 1) begin errors++; $display("FAIL eo_done got %0d exp 1", dn); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL eo_lo got %h exp 0", bus.lo); end
    checks++; if (bus.hi !== 32'h3) begin errors++; $display("FAIL eo_hi got %h exp 3", bus.hi); end
  endtask

  task automatic test_reset_mid;
    issue(3'b100, 32'd9, 32'd9);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rm_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rm_lo got %h exp 0", bus.lo); end
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL rm_done got %0d exp 0", dn); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.md_control = 3'b010;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.cancel = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mtmf();
    test_cancel();
    test_cancel_commit();
    test_start_while_busy();
    test_early_out();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit holding the architectural HI/LO registers for the pipelined MIPS core.
- Executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo using the 3-bit md_control encoding produced by the decoder.
- Drives busy back to the decoder, which stalls any later md instruction while busy is high.
- Sits beside the EX-stage ALU; operands come from the forwarded rs/rt values.

Parameters:
- WIDTH, 32: operand, HI and LO width in bits; must be at least 4.
- MULT_LAT, 4: number of busy cycles for mult/multu; must be at least 1.
- CNT_W, 6: iteration counter width; 2^CNT_W must be greater than max(WIDTH, MULT_LAT).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  request strobe; sampled only when busy=0.
- md_control  in  3  operation: 000 mfhi, 001 mflo, 010 mthi, 011 mtlo, 100 mult, 101 multu, 110 div, 111 divu.
- rs_val  in  WIDTH  first operand (multiplicand/dividend, or mthi/mtlo source).
- rt_val  in  WIDTH  second operand (multiplier/divisor).
- cancel  in  1  flush from branch or exception; aborts an in-flight operation.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO commit after mult/div.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.
- mf_data  out  WIDTH  combinational read: hi when md_control=000, lo when md_control=001, otherwise 0.

Behaviour:
Reset:
- Synchronous: when rst_n=0 at a rising edge, state goes to IDLE and busy=0, done=0, hi=0, lo=0, counter=0.
- Reset mid-operation discards the operation.

States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op 010/011: hi or lo <= rs_val on that edge; no busy cycle.
- IDLE, start=1, op 000/001: no state change; mf_data is valid in the same cycle.
- IDLE, start=1, op 10x: latch operands, counter <= MULT_LAT-1, go to MUL.
- IDLE, start=1, op 11x: latch operands, go to DIV.
- MUL:
  - Full 2*WIDTH-bit product; signed for mult, unsigned for multu.
  - Counter decrements each cycle; at 0, {hi,lo} <= product, done=1, return to IDLE.
  - busy is high for exactly MULT_LAT cycles.
- DIV:
  - Restoring shift-subtract on magnitudes (two's-complement absolute value for div), one quotient bit per cycle.
  - Runs WIDTH cycles, then goes to FIX.
- FIX:
  - Apply signs: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - lo <= quotient, hi <= remainder, done=1, go to IDLE.
  - busy is high for WIDTH+1 cycles total.
- Divide by zero: lo <= all ones, hi <= dividend, same latency as a normal divide.
- div of most-negative by -1: lo <= most-negative, hi <= 0; no trap.

Timing:
- busy goes high the cycle after the accepting edge.
- busy is low in the same cycle that done=1 and the new hi/lo are visible.

Boundary cases:
- start while busy=1: ignored (the decoder blocks it); no state change.
- cancel=1 in MUL/DIV/FIX: return to IDLE next edge; hi/lo unchanged; done stays 0.
- cancel in IDLE has no effect, and start is still processed if both are high.
- cancel and final-cycle commit on the same edge: cancel wins and there is no commit.
- rst_n=0 overrides cancel and start.

Optional Feature:
Macro MD_EARLY_OUT_EN.
- Defined: a div/divu whose divisor is 0, or whose divisor magnitude exceeds the dividend magnitude, bypasses DIV.
  - It goes straight to FIX with quotient 0 (or all ones for divisor 0) and remainder equal to the dividend.
  - busy lasts 1 cycle.
- Undefined: every divide takes WIDTH+1 cycles.
- Results are identical either way.

Test Plan:
1. Reset, then mult rs=0xFFFFFFFE (-2), rt=3 -> busy high 4 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
2. multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. div rs=-7 (0xFFFFFFF9), rt=2 -> busy 33 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 7/0 -> lo=0xFFFFFFFF, hi=7.
4. mthi rs=0x1234, then mtlo rs=0x5678, then mfhi/mflo -> mf_data=0x1234, then 0x5678, with no busy cycles.
5. div 100/7 started, cancel asserted at busy cycle 10 -> busy low next cycle; hi/lo keep prior values; done never pulses.
6. With MD_EARLY_OUT_EN: divu 3/10 -> busy 1 cycle, lo=0, hi=3. Without the macro: busy 33 cycles, same result. rst_n low mid-mult -> hi=lo=0, busy=0.
